// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the data RAM controller and its lane-alignment
//   helper: access-size encodings, controller state type and the
//   misalignment rule used to reject requests.
// ---------------------------------------------------------------------------
package mem_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_X = 2'd3;

  // Controller phases: zero-walk of the array, then normal traffic
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ctrlState_t;

  // An access is rejected when it would straddle its natural alignment,
  // or when the size encoding is the reserved value.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] offset);
    logic bad;
    case (size)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = offset[0];
      MEM_W:   bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align
//   Purely combinational lane logic between a byte-addressed request and a
//   32-bit memory word.
//   Ports:
//     size_i     access size (MEM_B/MEM_H/MEM_W, MEM_X reserved)
//     unsigned_i 1 zero-extend loads, 0 sign-extend (ignored for words)
//     offset_i   byte offset within the word (addr[1:0])
//     wdata_i    right-aligned store data
//     rword_i    word currently stored at the addressed location
//     be_o       byte-lane write enables (all zero on error)
//     wlane_o    store data replicated across the lanes
//     rdata_o    extracted and extended load data (zero on error)
//     err_o      misaligned or reserved-size access
// ---------------------------------------------------------------------------
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [31:0] shifted;

  // Stores replicate the low bytes across every lane so that the byte
  // enables alone select where they land. Loads bring the addressed byte
  // or half down to bit 0 before extension. Erroring accesses neither
  // write nor return data.
  always_comb begin
    err_o   = misaligned(size_i, offset_i);
    shifted = rword_i >> {offset_i, 3'b000};
    be_o    = 4'b0000;
    wlane_o = wdata_i;
    rdata_o = 32'h0;
    case (size_i)
      MEM_B: begin
        be_o    = 4'b0001 << offset_i;
        wlane_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        be_o    = 4'b0011 << offset_i;
        wlane_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      MEM_W: begin
        be_o    = 4'b1111;
        rdata_o = shifted;
      end
      default: begin
        be_o    = 4'b0000;
      end
    endcase
    if (err_o) begin
      be_o    = 4'b0000;
      rdata_o = 32'h0;
    end
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// ---------------------------------------------------------------------------
// data_ram_ctrl
//   Data memory for the core's load/store path. Byte-addressed LB/LH/LW/
//   LBU/LHU/SB/SH/SW requests are accepted through a valid/ready handshake
//   and answered after a fixed READ_LATENCY through an in-order pipeline.
//   After reset the array can optionally be walked and zeroed before any
//   traffic is accepted.
//   Ports:
//     clk, rst      rising-edge clock, asynchronous active-high reset
//     req_valid     request present; transfer = req_valid & req_ready
//     req_ready     high in RUN, low while clearing and in reset
//     req_we        1 store, 0 load
//     req_size      0 byte, 1 half, 2 word, 3 illegal
//     req_unsigned  loads: 1 zero-extend, 0 sign-extend
//     req_addr      byte address
//     req_wdata     right-aligned store data
//     resp_valid    one-cycle pulse per accepted request
//     resp_rdata    extended load data; 0 for stores and errors
//     resp_err      misaligned or illegal size (0 while resp_valid=0)
//     busy_clear    zero-walk in progress
// ---------------------------------------------------------------------------
module data_ram_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH          = 2048,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter     INIT_FILE      = "test//test.ram.hex",
  parameter int ADDR_W         = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy_clear
);

  localparam int WORD_W = ADDR_W - 2;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(DEPTH - 1);

  // The preload image is bound to the array by the implementation flow's
  // memory-initialisation step; the name is kept visible at elaboration.
  localparam bit unusedHasImage = (INIT_FILE != "");

  ctrlState_t        state_q, state_d;
  logic [WORD_W-1:0] clearCnt_q, clearCnt_d;
  logic              ready_q;
  logic              clearing;

  logic [31:0]       mem_q [DEPTH];

  logic              accept;
  logic [WORD_W-1:0] wordIdx;
  logic [31:0]       rword;
  logic [3:0]        byteEn;
  logic [31:0]       wlane;
  logic [31:0]       loadData;
  logic              alignErr;

  logic              vld_q  [READ_LATENCY];
  logic              err_q  [READ_LATENCY];
  logic [31:0]       data_q [READ_LATENCY];

  // State register. req_ready is registered from the next state so it is
  // low throughout reset even when the clear walk is skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clearCnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clearCnt_q <= clearCnt_d;
      ready_q    <= (state_d == ST_RUN);
    end
  end

  // Next state: one word is zeroed per cycle; the last word's write edge
  // also moves the controller into RUN.
  always_comb begin
    state_d    = state_q;
    clearCnt_d = clearCnt_q;
    if (state_q == ST_CLEAR) begin
      clearCnt_d = clearCnt_q + 1'b1;
      if (clearCnt_q == LAST_WORD) begin
        state_d = ST_RUN;
      end
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    clearing   = (state_q == ST_CLEAR);
    busy_clear = clearing;
    req_ready  = ready_q;
  end

  assign accept  = req_valid & req_ready;
  assign wordIdx = req_addr[ADDR_W-1:2];
  assign rword   = mem_q[wordIdx];

  mem_align u_align (
    .size_i     (req_size),
    .unsigned_i (req_unsigned),
    .offset_i   (req_addr[1:0]),
    .wdata_i    (req_wdata),
    .rword_i    (rword),
    .be_o       (byteEn),
    .wlane_o    (wlane),
    .rdata_o    (loadData),
    .err_o      (alignErr)
  );

  // The array itself has no reset; only the clear walk zeroes it. Reads
  // are combinational, so a load accepted on the same edge as nothing else
  // sees the value committed by the previous edge's store.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem_q[clearCnt_q] <= 32'h0;
    end else if (accept && req_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem_q[wordIdx][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline. Data and error only advance alongside a valid
  // token so the final stage holds the last response between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        err_q[i]  <= 1'b0;
        data_q[i] <= 32'h0;
      end
    end else begin
      vld_q[0] <= accept;
      if (accept) begin
        data_q[0] <= req_we ? 32'h0 : loadData;
        err_q[0]  <= alignErr;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          err_q[i]  <= err_q[i-1];
        end
      end
    end
  end

  assign resp_valid = vld_q[READ_LATENCY-1];
  assign resp_rdata = data_q[READ_LATENCY-1];
  assign resp_err   = vld_q[READ_LATENCY-1] & err_q[READ_LATENCY-1];

endmodule

// File: tb/tb_data_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_ram_ctrl
//   Scoreboard bench for data_ram_ctrl with DEPTH=16, READ_LATENCY=3.
//   Requests push their expected response onto queues; a monitor pops and
//   compares whenever resp_valid is seen. Expectations come from a byte-
//   array reference memory or from fixed constants for directed cases.
// ---------------------------------------------------------------------------
module tb_data_ram_ctrl;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int AW    = 6;
  localparam int BYTES = DEPTH * 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          busy_clear;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;

  logic [7:0]  refMem [BYTES];
  logic [31:0] expData [$];
  logic        expErr  [$];
  int          expCyc  [$];

  data_ram_ctrl #(
    .DEPTH          (DEPTH),
    .READ_LATENCY   (LAT),
    .CLEAR_ON_RESET (1),
    .INIT_FILE      ("")
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .busy_clear   (busy_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Overall time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte-level reference: memory is a flat byte array, little-endian.
  function automatic void modelAccess(input bit we, input logic [1:0] size,
                                      input bit uns, input int addr,
                                      input logic [31:0] wdata,
                                      output logic [31:0] rdata,
                                      output logic err);
    int n;
    logic [31:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || ((addr % n) != 0);
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int k = 0; k < n; k++) refMem[addr + k] = wdata[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = refMem[addr + k];
      if (!uns && n < 4 && v[8*n-1]) begin
        for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      end
      rdata = v;
    end
  endfunction

  // Drive one request for one cycle and record what it must return.
  task automatic applyStimulus(input bit we, input logic [1:0] size,
                               input bit uns, input int addr,
                               input logic [31:0] wdata, input bit useConst,
                               input logic [31:0] cData, input bit cErr);
    logic [31:0] md;
    logic me;
    @(negedge clk);
    checkOutput("req_ready_run", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr[AW-1:0];
    req_wdata    = wdata;
    modelAccess(we, size, uns, addr, wdata, md, me);
    expData.push_back(useConst ? cData : md);
    expErr.push_back(useConst ? cErr : me);
    expCyc.push_back(cycleCnt + LAT);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    idleCycles(1);
    while (expData.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("queue_drained", 32'(expData.size()), 32'd0);
  endtask

  // Called on the negedge at which reset is released.
  task automatic clearSequence(input string tag);
    int k;
    k = 0;
    while (busy_clear && k < 100) begin
      checkOutput({tag, "_ready_low"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_cycles"}, 32'(k), 32'(DEPTH));
    checkOutput({tag, "_ready_high"}, 32'(req_ready), 32'd1);
    for (int i = 0; i < BYTES; i++) refMem[i] = 8'h00;
  endtask

  task automatic flushExpected();
    expData.delete();
    expErr.delete();
    expCyc.delete();
  endtask

  // Monitor: every response pulse must match the head of the scoreboard
  // and arrive exactly LAT cycles after its accept edge.
  always @(negedge clk) begin : monitor
    logic [31:0] d;
    logic e;
    int c;
    if (!rst) begin
      if (resp_valid) begin
        if (expData.size() == 0) begin
          checkOutput("unexpected_resp_valid", 32'd1, 32'd0);
        end else begin
          d = expData.pop_front();
          e = expErr.pop_front();
          c = expCyc.pop_front();
          checkOutput("resp_rdata", resp_rdata, d);
          checkOutput("resp_err", 32'(resp_err), 32'(e));
          checkOutput("resp_latency", 32'(cycleCnt), 32'(c));
        end
      end else begin
        checkOutput("resp_err_idle", 32'(resp_err), 32'd0);
      end
    end
  end

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_busy_clear", 32'(busy_clear), 32'd1);
    rst = 1'b0;
    clearSequence("clear1");

    // Cleared array reads zero
    applyStimulus(0, 2'd2, 0, 'h3C, 0, 1, 32'h0, 0);

    // Word store then narrow loads with both extensions
    applyStimulus(1, 2'd2, 0, 'h10, 32'hDEADBEEF, 1, 32'h0, 0);
    applyStimulus(0, 2'd0, 0, 'h13, 0, 1, 32'hFFFFFFDE, 0);
    applyStimulus(0, 2'd0, 1, 'h13, 0, 1, 32'h000000DE, 0);
    applyStimulus(0, 2'd1, 0, 'h12, 0, 1, 32'hFFFFDEAD, 0);
    applyStimulus(0, 2'd1, 1, 'h10, 0, 1, 32'h0000BEEF, 0);

    // Byte and half merges into an existing word
    applyStimulus(1, 2'd2, 0, 'h10, 32'h11223344, 1, 32'h0, 0);
    applyStimulus(1, 2'd0, 0, 'h11, 32'h000000AA, 1, 32'h0, 0);
    applyStimulus(0, 2'd2, 0, 'h10, 0, 1, 32'h1122AA44, 0);
    applyStimulus(1, 2'd1, 0, 'h12, 32'h00005566, 1, 32'h0, 0);
    applyStimulus(0, 2'd2, 0, 'h10, 0, 1, 32'h5566AA44, 0);

    // Misaligned and illegal accesses leave memory untouched
    applyStimulus(1, 2'd2, 0, 'h20, 32'hCAFEF00D, 1, 32'h0, 0);
    applyStimulus(1, 2'd2, 0, 'h22, 32'h12345678, 1, 32'h0, 1);
    applyStimulus(1, 2'd1, 0, 'h21, 32'h0000ABCD, 1, 32'h0, 1);
    applyStimulus(1, 2'd3, 0, 'h20, 32'hFFFFFFFF, 1, 32'h0, 1);
    applyStimulus(0, 2'd2, 0, 'h20, 0, 1, 32'hCAFEF00D, 0);
    waitDrain();

    // Eight back-to-back word loads
    for (int i = 0; i < 8; i++) applyStimulus(0, 2'd2, 0, i * 4, 0, 0, 0, 0);
    waitDrain();

    // Randomised traffic with occasional idle cycles
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycles(1);
      applyStimulus($urandom_range(0, 1), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 1), $urandom_range(0, BYTES - 1),
                    $urandom, 0, 0, 0);
    end
    waitDrain();

    // Reset with two loads in flight: responses dropped, clear restarts
    applyStimulus(1, 2'd2, 0, 'h08, 32'hA5A5A5A5, 1, 32'h0, 0);
    waitDrain();
    applyStimulus(0, 2'd2, 0, 'h08, 0, 1, 32'hA5A5A5A5, 0);
    applyStimulus(0, 2'd2, 0, 'h0C, 0, 0, 0, 0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    flushExpected();
    repeat (2) @(negedge clk);
    checkOutput("midrun_rst_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    clearSequence("clear2");
    applyStimulus(0, 2'd2, 0, 'h08, 0, 1, 32'h0, 0);
    waitDrain();

    // Reset part way through the clear walk restarts the walk from word 0
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clearSequence("clear3");
    applyStimulus(0, 2'd2, 0, 'h3C, 0, 1, 32'h0, 0);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
